led7219_chain: RTL

Parametrised successor to the single-matrix LED debug driver. Drives a daisy chain of NDEV MAX7219 8x8 LED matrix controllers from a flat debug bit vector. It runs a register init sequence after reset, then refreshes all rows continuously. Each frame is taken from a consistent snapshot, which can be frozen for inspection. It sits at the top level beside the systime counter and feeds the three expansion-header pins that carry the LED matrix.

---
 rtl/led7219_chain.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/led7219_chain.sv
// Daisy-chain driver for NDEV MAX7219 8x8 LED matrices, fed from a flat debug vector.
// Optional periodic re-init is enabled by defining LED7219_REINIT_EN.
module led7219_chain #(
    parameter int unsigned NDEV          = 4,
    parameter int unsigned CLK_DIV       = 4,
    parameter logic [3:0]  INTENSITY     = 4'h8,
    parameter int unsigned REINIT_FRAMES = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NDEV*64-1:0] data,
    input  logic               freeze,
    output logic               leds_out,
    output logic               leds_cs,
    output logic               leds_clk,
    output logic               init_done,
    output logic               frame_done
);

    localparam int unsigned DW   = (NDEV > 1) ? $clog2(NDEV) : 1;
    localparam int unsigned DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV + 1) : 1;

    localparam logic [DW-1:0]   DEV_LAST = DW'(NDEV - 1);
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD     = 3'd1;
    localparam logic [2:0] S_CS_SETUP = 3'd2;
    localparam logic [2:0] S_BIT_LO   = 3'd3;
    localparam logic [2:0] S_BIT_HI   = 3'd4;
    localparam logic [2:0] S_CS_HOLD  = 3'd5;
    localparam logic [2:0] S_GAP      = 3'd6;

    if (NDEV < 1 || NDEV > 16 || CLK_DIV < 1 || REINIT_FRAMES < 1) begin : g_param_check
        $error("led7219_chain: parameter out of range");
    end

    logic [2:0]         r_state;
    logic [3:0]         r_bit;
    logic [DW-1:0]      r_dev;
    logic [2:0]         r_step;
    logic [DIVW-1:0]    r_div;
    logic               r_gap_half;
    logic               r_refresh;
    logic [NDEV*64-1:0] r_shadow;
    logic               r_out;
    logic               r_cs;
    logic               r_sclk;
    logic               r_init_done;
    logic               r_frame_done;

`ifdef LED7219_REINIT_EN
    localparam int unsigned FRW = (REINIT_FRAMES > 1) ? $clog2(REINIT_FRAMES + 1) : 1;
    localparam logic [FRW-1:0] FR_LAST = FRW'(REINIT_FRAMES - 1);
    logic [FRW-1:0] r_frames;
`endif

    logic [15:0] w_word;
    logic [7:0]  w_row_byte;
    logic [3:0]  w_addr;
    logic [3:0]  w_bit_dn;
    logic        w_div_last;

    assign w_bit_dn   = r_bit - 4'd1;
    assign w_div_last = (r_div == DIV_LAST);

    // The word is derived from the shadow on demand, so a snapshot taken in the
    // first LOAD of a frame is already visible when its first bit is driven.
    always_comb begin
        w_row_byte = '0;
        for (int unsigned d = 0; d < NDEV; d++) begin
            for (int unsigned r = 0; r < 8; r++) begin
                if (r_dev == DW'(d) && r_step == 3'(r)) begin
                    w_row_byte = r_shadow[d*64 + r*8 +: 8];
                end
            end
        end
        w_addr = {1'b0, r_step} + 4'd1;
        if (!r_refresh) begin
            case (r_step)
                3'd0:    w_word = 16'h0C01;
                3'd1:    w_word = 16'h0900;
                3'd2:    w_word = 16'h0B07;
                3'd3:    w_word = {8'h0A, 4'h0, INTENSITY};
                default: w_word = 16'h0F00;
            endcase
        end else begin
            w_word = {4'h0, w_addr, w_row_byte};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_bit        <= '0;
            r_dev        <= '0;
            r_step       <= '0;
            r_div        <= '0;
            r_gap_half   <= 1'b0;
            r_refresh    <= 1'b0;
            r_shadow     <= '0;
            r_out        <= 1'b0;
            r_cs         <= 1'b1;
            r_sclk       <= 1'b0;
            r_init_done  <= 1'b0;
            r_frame_done <= 1'b0;
`ifdef LED7219_REINIT_EN
            r_frames     <= '0;
`endif
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_dev   <= DEV_LAST;
                    r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_bit <= 4'd15;
                    r_div <= '0;
                    if (r_dev == DEV_LAST) begin
                        if (r_refresh && r_step == 3'd0 && !freeze) begin
                            r_shadow <= data;
                        end
                        r_cs    <= 1'b0;
                        r_state <= S_CS_SETUP;
                    end else begin
                        r_out   <= w_word[4'd15];
                        r_state <= S_BIT_LO;
                    end
                end
                S_CS_SETUP: begin
                    if (w_div_last) begin
                        r_div   <= '0;
                        r_out   <= w_word[r_bit];
                        r_state <= S_BIT_LO;
                    end else begin
                        r_div <= r_div + DIVW'(1);
                    end
                end
                S_BIT_LO: begin
                    if (w_div_last) begin
                        r_div   <= '0;
                        r_sclk  <= 1'b1;
                        r_state <= S_BIT_HI;
                    end else begin
                        r_div <= r_div + DIVW'(1);
                    end
                end
                S_BIT_HI: begin
                    if (w_div_last) begin
                        r_div  <= '0;
                        r_sclk <= 1'b0;
                        if (r_bit != 4'd0) begin
                            r_bit   <= w_bit_dn;
                            r_out   <= w_word[w_bit_dn];
                            r_state <= S_BIT_LO;
                        end else if (r_dev != '0) begin
                            r_dev   <= r_dev - DW'(1);
                            r_state <= S_LOAD;
                        end else begin
                            r_state <= S_CS_HOLD;
                        end
                    end else begin
                        r_div <= r_div + DIVW'(1);
                    end
                end
                S_CS_HOLD: begin
                    if (w_div_last) begin
                        r_div      <= '0;
                        r_cs       <= 1'b1;
                        r_gap_half <= 1'b0;
                        r_state    <= S_GAP;
                        if (r_refresh && r_step == 3'd7) begin
                            r_frame_done <= 1'b1;
                        end
                        if (!r_refresh && r_step == 3'd4) begin
                            r_init_done <= 1'b1;
                        end
                    end else begin
                        r_div <= r_div + DIVW'(1);
                    end
                end
                S_GAP: begin
                    // Two passes of the divider give 2*CLK_DIV cycles without widening it.
                    if (w_div_last) begin
                        r_div <= '0;
                        if (!r_gap_half) begin
                            r_gap_half <= 1'b1;
                        end else begin
                            r_dev   <= DEV_LAST;
                            r_state <= S_LOAD;
                            if (!r_refresh) begin
                                if (r_step == 3'd4) begin
                                    r_refresh <= 1'b1;
                                    r_step    <= '0;
                                end else begin
                                    r_step <= r_step + 3'd1;
                                end
                            end else if (r_step == 3'd7) begin
                                r_step <= '0;
`ifdef LED7219_REINIT_EN
                                if (r_frames == FR_LAST) begin
                                    r_frames  <= '0;
                                    r_refresh <= 1'b0;
                                end else begin
                                    r_frames <= r_frames + FRW'(1);
                                end
`endif
                            end else begin
                                r_step <= r_step + 3'd1;
                            end
                        end
                    end else begin
                        r_div <= r_div + DIVW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign leds_out   = r_out;
    assign leds_cs    = r_cs;
    assign leds_clk   = r_sclk;
    assign init_done  = r_init_done;
    assign frame_done = r_frame_done;

endmodule
